// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: 16-way round-robin arbiter with registered grant index.
// Grants are held until gnt_ack or a HOLD_MAX-cycle timeout forces release.
module rr_grant_encoder #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        gnt_ack,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic        timeout,
  output logic        busy
);

  localparam int CW =
    (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [3:0]      ptr;
  logic [CW-1:0]   cnt;
  logic [3:0]      sel;
  logic            found;
  logic [3:0]      scan;

  // First requester at or after ptr, wrapping past 15.
  always_comb begin
    sel   = 4'd0;
    found = 1'b0;
    scan  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      scan = ptr + 4'(i);
      if (!found && req[scan]) begin
        found = 1'b1;
        sel   = scan;
      end
    end
  end

  // Grant FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= 4'd0;
      timeout   <= 1'b0;
      ptr       <= 4'd0;
      cnt       <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_idx   <= sel;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (gnt_ack) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 4'd1;
          end else if (cnt == LAST) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 4'd1;
            timeout   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = gnt_valid;

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter for 16 requesters; emits the registered 4-bit index of the granted requester plus a valid flag.
- Sits directly upstream of the team's 4-to-16 one-hot decoder: gnt_idx drives the decoder's 4-bit select, gnt_valid qualifies its 16-bit one-hot output.
- Grant is held until the owner acknowledges or a hold timeout forces release.

Parameters:
- HOLD_MAX, 8, max cycles a grant may be held without gnt_ack; legal range 1..256; counter width clog2(HOLD_MAX), minimum 1 bit.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- req  input  16  request vector; bit i = requester i
- gnt_ack  input  1  owner releases grant; honoured only while gnt_valid=1
- gnt_valid  output  1  grant active; gnt_idx meaningful
- gnt_idx  output  4  index of granted requester; feeds decoder select
- timeout  output  1  one-cycle pulse: last grant was force-released
- busy  output  1  equals gnt_valid; for status visibility

Behaviour:
- Reset (rst=1 at edge): state IDLE, gnt_valid=0, gnt_idx=0, timeout=0, busy=0, priority pointer ptr=0, hold counter=0. Reset overrides everything, including mid-grant; no timeout pulse is produced by reset.
- States: IDLE, GRANT. All outputs are registered; no combinational path from inputs to outputs.
- IDLE, req==0: remain IDLE; outputs unchanged, except timeout returns to 0.
- IDLE, req!=0 at edge:
  - Select the first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Next cycle: gnt_idx=selected index, gnt_valid=1, state GRANT, counter=0.
  - Latency: req sampled at edge t -> gnt_valid high after edge t.
- GRANT, evaluated at each edge, in priority order:
  1. gnt_ack=1: release. State IDLE, gnt_valid=0, ptr=gnt_idx+1 mod 16 (15 wraps to 0), timeout=0.
  2. Else if counter==HOLD_MAX-1: forced release. Same updates as ack, and timeout=1 for exactly the following cycle.
  3. Else: counter+1; stay in GRANT.
- Max grant length: HOLD_MAX cycles of gnt_valid=1.
- Ack arriving on the same edge as counter==HOLD_MAX-1 wins; timeout stays 0.
- After any release, gnt_valid is low for at least one cycle; a new grant cannot start until the following edge. Minimum grant-to-grant spacing is 1 idle cycle.
- gnt_idx holds its last value while gnt_valid=0. The downstream consumer must gate on gnt_valid.
- req changes during GRANT are ignored, including the owner dropping its req; the grant persists until ack or timeout.
- gnt_ack while gnt_valid=0 is ignored.
- HOLD_MAX=1: every grant lasts 1 cycle; with no ack in that cycle, the grant is force-released with a timeout pulse.

Test Plan:
- Reset with req=16'hFFFF held -> during rst all outputs 0; first edge after rst deasserts -> gnt_idx=0, gnt_valid=1.
- req=16'h8001, ack one cycle after each grant -> grants alternate 0, 15, 0, 15, with one idle cycle of gnt_valid=0 between grants.
- Wrap: ptr=15 (after granting 14), req=16'h4001 -> grant 0, not 14.
- HOLD_MAX=8, req=16'h0010, no ack -> gnt_idx=4, gnt_valid high exactly 8 cycles, then timeout=1 for 1 cycle; next grant is idx 4 again (only requester).
- Ack on the 8th held cycle -> release with timeout=0. Ack while idle -> no state change. req bit 4 drops mid-grant -> grant still held.
- Mid-grant rst=1 -> next cycle gnt_valid=0, timeout=0, ptr=0; with req=16'h0300 the next grant is 8.
